// File: rtl/board_plotter.sv
// board_plotter: reader side of the board RAM. On a start pulse it walks the board
// row by row. For each row it fetches one COLS-bit word and draws every cell as a
// CELL x CELL pixel block, writing one pixel to the VGA adapter per cycle.
//
// Ports:
//   clk, reset_n        clock; asynchronous active-low reset
//   start, abort        begin a redraw (IDLE only) / cancel a redraw (no done pulse)
//   row_addr, row_rd    RAM row address (always the current row) and read strobe
//   row_data            RAM read data; column 0 is the MSB
//   x, y, colour, plot  pixel write towards the VGA adapter (zero outside PLOT)
//   busy, done          redraw in progress / one-cycle completion pulse
module board_plotter #(
  parameter int unsigned COLS         = 40,
  parameter int unsigned ROWS         = 30,
  parameter int unsigned CELL         = 4,
  parameter int unsigned RD_LATENCY   = 1,
  parameter logic [2:0]  ALIVE_COLOUR = 3'b010,
  parameter logic [2:0]  DEAD_COLOUR  = 3'b000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  output logic [4:0]      row_addr,
  output logic            row_rd,
  input  logic [COLS-1:0] row_data,
  output logic [7:0]      x,
  output logic [6:0]      y,
  output logic [2:0]      colour,
  output logic            plot,
  output logic            busy,
  output logic            done
);

  localparam int unsigned Pix = CELL * CELL;
  localparam int unsigned PW  = (Pix > 1) ? $clog2(Pix) : 1;
  localparam int unsigned CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned WW  = $clog2(RD_LATENCY + 1);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StPlot, StDone} state_e;

  state_e          state_q, state_d;
  logic [4:0]      row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [PW-1:0]   pix_q, pix_d;
  logic [WW-1:0]   wait_q, wait_d;
  // Row word; shifted left once per finished cell so the current cell is always the MSB.
  logic [COLS-1:0] bits_q, bits_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      pix_q   <= '0;
      wait_q  <= '0;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pix_q   <= pix_d;
      wait_q  <= wait_d;
      bits_q  <= bits_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    pix_d    = pix_q;
    wait_d   = wait_q;
    bits_d   = bits_q;
    row_rd   = 1'b0;
    x        = '0;
    y        = '0;
    colour   = '0;
    plot     = 1'b0;
    done     = 1'b0;
    row_addr = row_q;
    busy     = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          row_d   = '0;
          col_d   = '0;
          pix_d   = '0;
          wait_d  = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        row_rd  = 1'b1;
        wait_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (wait_q == WW'(RD_LATENCY - 1)) begin
          bits_d  = row_data;
          col_d   = '0;
          pix_d   = '0;
          state_d = StPlot;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      StPlot: begin
        plot   = 1'b1;
        x      = 8'((32'(col_q) * CELL) + (32'(pix_q) % CELL));
        y      = 7'((32'(row_q) * CELL) + (32'(pix_q) / CELL));
        colour = bits_q[COLS-1] ? ALIVE_COLOUR : DEAD_COLOUR;
        if (pix_q == PW'(Pix - 1)) begin
          pix_d  = '0;
          bits_d = bits_q << 1;
          if (col_q == CW'(COLS - 1)) begin
            col_d = '0;
            if (row_q == 5'(ROWS - 1)) begin
              state_d = StDone;
            end else begin
              row_d   = row_q + 5'd1;
              state_d = StFetch;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end else begin
          pix_d = pix_q + PW'(1);
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // abort beats start in IDLE and cancels any redraw in progress without a done pulse.
    if (abort) begin
      state_d = StIdle;
      row_d   = '0;
      col_d   = '0;
      pix_d   = '0;
      wait_d  = '0;
    end
  end

endmodule
